// File: rtl/cat_dot_product_engine.sv
// Cat classifier dot-product engine: streams pixel/weight words, accumulates lane products plus bias.
// Optional macro CAT_ACC_SATURATE_EN clamps every accumulator add instead of wrapping.
module cat_dot_product_engine #(
  parameter int unsigned AMBA_WORD        = 24,
  parameter int unsigned AMBA_ADDR_DEPTH  = 13,
  parameter int unsigned WEIGHT_PRECISION = 5,
  parameter int unsigned NUM_WORDS        = 1024,
  parameter int unsigned ACC_WIDTH        = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       read_en,
  output logic [AMBA_ADDR_DEPTH-1:0] read_address,
  input  logic [AMBA_WORD-1:0]       pixel_data,
  input  logic [AMBA_WORD-1:0]       weight_data,
  input  logic [ACC_WIDTH-1:0]       bias,
  output logic                       busy,
  output logic [ACC_WIDTH-1:0]       acc_val,
  output logic                       last_result,
  output logic                       done
);

  localparam int unsigned LANES  = AMBA_WORD / 8;
  localparam int unsigned PROD_W = 9 + WEIGHT_PRECISION;
  localparam int unsigned SUM_W  = PROD_W + $clog2(LANES);
  localparam int unsigned EXT_W  = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 1;
  localparam logic [AMBA_ADDR_DEPTH-1:0] LAST_ADDR = AMBA_ADDR_DEPTH'(NUM_WORDS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, BIAS, DONE} state_t;

  state_t                      state, next_state;
  logic                        valid;
  logic [ACC_WIDTH-1:0]        bias_q;
  logic signed [SUM_W-1:0]     lane_sum_c;
  logic signed [ACC_WIDTH-1:0] acc_next_c;
  logic signed [ACC_WIDTH-1:0] biased_c;
  logic                        unused_weight;

  // Upper lane bits of the weight word carry no information.
  assign unused_weight = ^weight_data;

  // Add in a widened domain so overflow is visible, then wrap or clamp.
  function automatic logic signed [ACC_WIDTH-1:0] acc_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [EXT_W-1:0]     b
  );
    logic signed [EXT_W-1:0] s;
    logic signed [EXT_W-1:0] hi;
    logic signed [EXT_W-1:0] lo;
    s  = EXT_W'(a) + b;
    hi = EXT_W'(signed'({1'b0, {(ACC_WIDTH-1){1'b1}}}));
    lo = EXT_W'(signed'({1'b1, {(ACC_WIDTH-1){1'b0}}}));
`ifdef CAT_ACC_SATURATE_EN
    if (s > hi)      return hi[ACC_WIDTH-1:0];
    else if (s < lo) return lo[ACC_WIDTH-1:0];
    else             return s[ACC_WIDTH-1:0];
`else
    if (hi == lo) return '0;
    return s[ACC_WIDTH-1:0];
`endif
  endfunction

  // Sum of unsigned pixel lane times sign-extended weight lane.
  always_comb begin
    logic signed [PROD_W-1:0] px;
    logic signed [PROD_W-1:0] wt;
    lane_sum_c = '0;
    px = '0;
    wt = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      px = signed'(PROD_W'({1'b0, pixel_data[8*l +: 8]}));
      wt = PROD_W'(signed'(weight_data[8*l +: WEIGHT_PRECISION]));
      lane_sum_c = lane_sum_c + SUM_W'(px * wt);
    end
  end

  assign acc_next_c = acc_add(signed'(acc_val), EXT_W'(lane_sum_c));
  assign biased_c   = acc_add(signed'(acc_val), EXT_W'(signed'(bias_q)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = FETCH;
      FETCH:   if (read_address == LAST_ADDR) next_state = DRAIN;
      DRAIN:   next_state = BIAS;
      BIAS:    next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs and datapath, driven from the current/next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_en      <= 1'b0;
      read_address <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      acc_val      <= '0;
      last_result  <= 1'b0;
      valid        <= 1'b0;
      bias_q       <= '0;
    end else begin
      valid <= read_en;
      busy  <= (next_state inside {FETCH, DRAIN, BIAS});
      done  <= (next_state == DONE);
      if (valid) acc_val <= acc_next_c;
      case (state)
        IDLE: if (start) begin
          acc_val      <= '0;
          bias_q       <= bias;
          read_address <= '0;
          read_en      <= 1'b1;
        end
        FETCH: begin
          if (read_address == LAST_ADDR) read_en <= 1'b0;
          else read_address <= read_address + AMBA_ADDR_DEPTH'(1);
        end
        BIAS: begin
          acc_val     <= biased_c;
          last_result <= !biased_c[ACC_WIDTH-1] && (biased_c != '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cat_dot_product_engine.sv
// Self-checking bench for cat_dot_product_engine against an arithmetic reference model.
module tb_cat_dot_product_engine;

  localparam int NW  = 4;
  localparam int WIN = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic        read_en, read_en2;
  logic [12:0] read_address, read_address2;
  logic [23:0] pixel_data = '0, weight_data = '0;
  logic [23:0] pixel_data2 = '0, weight_data2 = '0;
  logic [31:0] bias_in = '0;
  logic        busy, busy2, last_result, last_result2, done, done2;
  logic [31:0] acc_val;
  logic [11:0] acc_val2;

  logic [23:0] pix_mem [0:NW-1];
  logic [23:0] wt_mem  [0:NW-1];

  int checks = 0;
  int errors = 0;
  int done_cycle, done_count;
  int addr_q[$];
  logic busy_log [0:WIN];

  always #5 clk = ~clk;

  cat_dot_product_engine #(.NUM_WORDS(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .read_en(read_en), .read_address(read_address),
    .pixel_data(pixel_data), .weight_data(weight_data), .bias(bias_in), .busy(busy),
    .acc_val(acc_val), .last_result(last_result), .done(done)
  );

  cat_dot_product_engine #(.NUM_WORDS(NW), .ACC_WIDTH(12)) dut12 (
    .clk(clk), .rst(rst), .start(start2), .read_en(read_en2), .read_address(read_address2),
    .pixel_data(pixel_data2), .weight_data(weight_data2), .bias(12'd0), .busy(busy2),
    .acc_val(acc_val2), .last_result(last_result2), .done(done2)
  );

  // Synchronous memories: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (read_en) begin
      pixel_data  <= pix_mem[read_address[1:0]];
      weight_data <= wt_mem[read_address[1:0]];
    end
    if (read_en2) begin
      pixel_data2  <= pix_mem[read_address2[1:0]];
      weight_data2 <= wt_mem[read_address2[1:0]];
    end
  end

  function automatic longint model_fit(input longint v, input int w);
    longint m;
    longint r;
    m = longint'(1) <<< w;
`ifdef CAT_ACC_SATURATE_EN
    if (v > m / 2 - 1) return m / 2 - 1;
    if (v < -(m / 2))  return -(m / 2);
    return v;
`else
    r = v % m;
    if (r < 0) r = r + m;
    if (r >= m / 2) r = r - m;
    return r;
`endif
  endfunction

  function automatic longint model_acc(input int w, input longint b);
    longint acc;
    longint term;
    longint p;
    longint q;
    acc = 0;
    for (int i = 0; i < NW; i++) begin
      term = 0;
      for (int l = 0; l < 3; l++) begin
        p = longint'(pix_mem[i] >> (8 * l)) & 255;
        q = longint'(wt_mem[i] >> (8 * l)) & 31;
        if (q >= 16) q = q - 32;
        term = term + p * q;
      end
      acc = model_fit(acc + term, w);
    end
    return model_fit(acc + b, w);
  endfunction

  task automatic fill(input logic [23:0] px, input logic [23:0] wt);
    for (int i = 0; i < NW; i++) begin
      pix_mem[i] = px;
      wt_mem[i]  = wt;
    end
  endtask

  // Start in cycle 0, then observe cycles 1..WIN; optional extra start / reset injection.
  task automatic run_image(input int inject_start, input int rst_at, input logic [31:0] b);
    addr_q.delete();
    done_count = 0;
    done_cycle = 0;
    @(negedge clk);
    bias_in = b;
    start = 1'b1;
    for (int c = 1; c <= WIN; c++) begin
      @(posedge clk);
      #1;
      busy_log[c] = busy;
      if (read_en) addr_q.push_back(int'(read_address));
      if (done) begin
        done_count++;
        if (done_cycle == 0) done_cycle = c;
      end
      start = (c == inject_start);
      rst   = (c == rst_at);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({read_en, read_address, busy, done, acc_val, last_result} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%0b addr=%0d busy=%0b done=%0b acc=%0d last=%0b want all zero",
               read_en, read_address, busy, done, acc_val, last_result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    longint exp;
    // All +1 weights on saturated pixels, then all -1, then zero pixels with bias 0 and 1.
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: fill(24'hFFFFFF, 24'h010101);
        1: fill(24'hFFFFFF, 24'h1F1F1F);
        default: fill(24'h000000, 24'h0A0A0A);
      endcase
      run_image(-1, -1, (k == 3) ? 32'd1 : 32'd0);
      exp = model_acc(32, (k == 3) ? 1 : 0);
      checks++;
      if (acc_val !== 32'(exp)) begin
        errors++;
        $display("FAIL directed_acc[%0d]: got %0d want %0d", k, $signed(acc_val), exp);
      end
      checks++;
      if (last_result !== (exp > 0)) begin
        errors++;
        $display("FAIL directed_last[%0d]: got %0b want %0b", k, last_result, exp > 0);
      end
      checks++;
      if (done_cycle != NW + 3 || done_count != 1) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got cycle %0d count %0d want cycle %0d count 1",
                 k, done_cycle, done_count, NW + 3);
      end
    end
    fill(24'hFFFFFF, 24'h010101);
    run_image(-1, -1, 32'd0);
    checks++;
    if ($signed(acc_val) !== 32'sd3060) begin
      errors++;
      $display("FAIL spec_value_3060: got %0d want 3060", $signed(acc_val));
    end
    checks++;
    if (addr_q.size() != NW) begin
      errors++;
      $display("FAIL addr_count: got %0d want %0d", addr_q.size(), NW);
    end
    for (int i = 0; i < addr_q.size(); i++) begin
      checks++;
      if (addr_q[i] != i) begin
        errors++;
        $display("FAIL addr_seq[%0d]: got %0d want %0d", i, addr_q[i], i);
      end
    end
    for (int c = 1; c <= NW + 5; c++) begin
      checks++;
      if (busy_log[c] !== (c <= NW + 2)) begin
        errors++;
        $display("FAIL busy_cycle[%0d]: got %0b want %0b", c, busy_log[c], c <= NW + 2);
      end
    end
  endtask

  task automatic test_random;
    longint exp;
    int b;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NW; i++) begin
        pix_mem[i] = 24'($urandom);
        wt_mem[i]  = 24'($urandom);
      end
      b = int'($urandom_range(0, 20000)) - 10000;
      run_image(-1, -1, 32'(b));
      exp = model_acc(32, longint'(b));
      checks++;
      if (acc_val !== 32'(exp) || last_result !== (exp > 0) || done_cycle != NW + 3) begin
        errors++;
        $display("FAIL random[%0d]: got acc=%0d last=%0b cycle=%0d want acc=%0d last=%0b cycle=%0d",
                 k, $signed(acc_val), last_result, done_cycle, exp, exp > 0, NW + 3);
      end
    end
  endtask

  task automatic test_start_ignored;
    fill(24'hFFFFFF, 24'h010101);
    run_image(2, -1, 32'd0);
    checks++;
    if (done_count != 1 || $signed(acc_val) !== 32'sd3060) begin
      errors++;
      $display("FAIL start_in_fetch: got done_count=%0d acc=%0d want 1 and 3060", done_count, $signed(acc_val));
    end
    run_image(NW + 3, -1, 32'd0);
    checks++;
    if (done_count != 1 || busy_log[NW + 4] !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: got done_count=%0d busy_after=%0b want 1 and 0", done_count, busy_log[NW + 4]);
    end
  endtask

  task automatic test_back_to_back;
    fill(24'h804020, 24'h1F0305);
    run_image(NW + 4, -1, 32'd7);
    checks++;
    if (done_count != 2 || acc_val !== 32'(model_acc(32, 7))) begin
      errors++;
      $display("FAIL back_to_back: got done_count=%0d acc=%0d want 2 and %0d",
               done_count, $signed(acc_val), model_acc(32, 7));
    end
  endtask

  task automatic test_mid_reset;
    fill(24'hFFFFFF, 24'h010101);
    run_image(-1, 3, 32'd0);
    checks++;
    if (done_count != 0 || busy !== 1'b0 || acc_val !== 32'd0 || busy_log[4] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got done_count=%0d busy=%0b acc=%0d want 0 0 0",
               done_count, busy, $signed(acc_val));
    end
    run_image(-1, -1, 32'd0);
    checks++;
    if ($signed(acc_val) !== 32'sd3060 || last_result !== 1'b1 || done_cycle != NW + 3) begin
      errors++;
      $display("FAIL after_reset: got acc=%0d last=%0b cycle=%0d want 3060 1 %0d",
               $signed(acc_val), last_result, done_cycle, NW + 3);
    end
  endtask

  task automatic test_narrow_acc;
    int dc;
    logic [11:0] want;
    fill(24'hFFFFFF, 24'h0F0F0F);
`ifdef CAT_ACC_SATURATE_EN
    want = 12'd2047;
`else
    want = 12'd844;
`endif
    dc = 0;
    @(negedge clk);
    start2 = 1'b1;
    for (int c = 1; c <= WIN && dc == 0; c++) begin
      @(posedge clk);
      #1;
      start2 = 1'b0;
      if (done2) dc = c;
    end
    checks++;
    if (dc != NW + 3) begin
      errors++;
      $display("FAIL narrow_latency: got %0d want %0d", dc, NW + 3);
    end
    checks++;
    if (acc_val2 !== want || acc_val2 !== 12'(model_acc(12, 0))) begin
      errors++;
      $display("FAIL narrow_acc: got %0d want %0d", acc_val2, want);
    end
    checks++;
    if (last_result2 !== 1'b1) begin
      errors++;
      $display("FAIL narrow_last: got %0b want 1", last_result2);
    end
  endtask

  initial begin
    fill(24'h0, 24'h0);
    test_reset;
    test_directed;
    test_random;
    test_start_ignored;
    test_back_to_back;
    test_mid_reset;
    test_narrow_acc;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cat_dot_product_engine.md
CAT_DOT_PRODUCT_ENGINE -- requirements
Module: cat_dot_product_engine

Interface
REQ-001 SHALL have parameter AMBA_WORD, default 24: pixel and weight word width, three 8-bit lanes per word.
REQ-002 SHALL have parameter AMBA_ADDR_DEPTH, default 13: read address width.
REQ-003 SHALL have parameter WEIGHT_PRECISION, default 5: signed two's-complement weight width, one weight per lane in the low WEIGHT_PRECISION bits of each 8-bit lane.
REQ-004 SHALL have parameter NUM_WORDS, default 1024: words per image, with 1 <= NUM_WORDS <= 2^AMBA_ADDR_DEPTH.
REQ-005 SHALL have parameter ACC_WIDTH, default 32: signed accumulator width.
REQ-006 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request to classify the stored image.
- read_en  out  1  read strobe to the pixel and weight memories.
- read_address  out  AMBA_ADDR_DEPTH  shared address for both memories.
- pixel_data  in  AMBA_WORD  unsigned pixel word, valid one cycle after read_en.
- weight_data  in  AMBA_WORD  weight word, valid one cycle after read_en.
- bias  in  ACC_WIDTH  signed bias, sampled when start is accepted.
- busy  out  1  high from start acceptance until done.
- acc_val  out  ACC_WIDTH  signed running/final accumulator.
- last_result  out  1  1 = cat, 0 = not cat; held until the next completion.
- done  out  1  one-cycle completion pulse.

Function
REQ-007 FSM states SHALL be IDLE, FETCH, DRAIN, BIAS, DONE.
REQ-008 IDLE SHALL accept start, clear acc_val, latch bias, set read_address=0, and go to FETCH.
REQ-009 FETCH SHALL assert read_en for exactly NUM_WORDS consecutive cycles, with addresses 0..NUM_WORDS-1 in increasing order.
REQ-010 After the last address is issued, FETCH SHALL go to DRAIN for one cycle to consume the final returned word.
REQ-011 A one-cycle valid pipeline flag SHALL qualify returned data; on each valid cycle acc_val SHALL increment by the sum over lanes 0..2 of unsigned pixel lane times sign-extended weight lane.
REQ-012 BIAS SHALL add the latched bias to acc_val.
REQ-013 DONE SHALL pulse done for one cycle, set last_result = (acc_val > 0) as a strict signed compare, and return to IDLE.
REQ-014 done SHALL assert exactly NUM_WORDS+3 cycles after the cycle in which start was sampled.
REQ-015 busy SHALL be 1 in FETCH, DRAIN and BIAS, and 0 in IDLE and DONE.
REQ-016 start SHALL be ignored when the FSM is not in IDLE, including in the DONE cycle.
REQ-017 read_address SHALL hold its last value when read_en=0.
REQ-018 acc_val and last_result SHALL hold their values in IDLE until the next accepted start; acc_val is cleared on acceptance, last_result is not.
REQ-019 Lane bits above WEIGHT_PRECISION in weight_data SHALL be ignored.

Reset
REQ-020 rst SHALL asynchronously force: state=IDLE, read_en=0, read_address=0, busy=0, done=0, acc_val=0, last_result=0, valid flag=0.
REQ-021 Reset mid-operation SHALL abandon the image with no done pulse.
REQ-022 The first start after reset deassertion SHALL be accepted normally.

Configuration
REQ-023 With macro CAT_ACC_SATURATE_EN defined, every accumulate and bias add SHALL clamp to [-(2^(ACC_WIDTH-1)), 2^(ACC_WIDTH-1)-1].
REQ-024 Without CAT_ACC_SATURATE_EN, additions SHALL wrap modulo 2^ACC_WIDTH.
REQ-025 Timing and all other behaviour SHALL be identical with and without the macro.

Verification (NUM_WORDS=4 unless stated)
REQ-026 Pixels 0xFFFFFF, all weights +1, bias 0, start -> acc_val=3060, last_result=1, done 7 cycles after start, addresses 0,1,2,3.
REQ-027 Pixels 0xFFFFFF, all weights -1 (lane 0x1F), bias 0 -> acc_val=-3060, last_result=0.
REQ-028 Pixels 0, bias 0 -> acc_val=0, last_result=0 (strict compare); repeat with bias=1 -> last_result=1.
REQ-029 Start re-pulsed at cycle 2 -> ignored, single done. rst at cycle 3 -> busy=0, acc_val=0, no done; a following start completes with the REQ-026 values.
REQ-030 ACC_WIDTH=12, pixels 0xFFFFFF, weights +15, bias 0:
- with CAT_ACC_SATURATE_EN -> acc_val=2047, last_result=1.
- without the macro -> acc_val=844, last_result=1.
